// File: rtl/jump_sequencer.sv
// Frame-rate doodle motion and game-phase controller: sequences Y, velocity,
// screen scroll and bounce score once per video frame.
module jump_sequencer #(
  parameter int Y_START     = 400,
  parameter int V_JUMP      = 12,
  parameter int V_MAX       = 15,
  parameter int G_DIV       = 4,
  parameter int SCROLL_LINE = 160,
  parameter int Y_FLOOR     = 479
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        ack,
  input  logic        plat_hit,
  output logic [9:0]  doodle_y,
  output logic [4:0]  scroll_amt,
  output logic        scroll_vld,
  output logic [15:0] score,
  output logic        q_I,
  output logic        q_Up,
  output logic        q_Down,
  output logic        q_Done
);

  localparam int GW = (G_DIV > 1) ? $clog2(G_DIV) : 1;

  typedef enum logic [3:0] {
    S_INIT = 4'b0001,
    S_UP   = 4'b0010,
    S_DOWN = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  state_t r_state, w_stateNxt;

  logic [9:0]    r_y, w_yNxt;
  logic [4:0]    r_vel, w_velNxt;
  logic [GW-1:0] r_grav, w_gravNxt;
  logic [15:0]   r_score, w_scoreNxt;
  logic [4:0]    r_scrollAmt, w_scrollAmtNxt;
  logic          r_scrollVld, w_scrollVldNxt;

  // Y arithmetic is carried in 11 bits so a rise or fall can never wrap
  logic [10:0]   w_yExt, w_nyUp, w_nyDown;
  logic          w_gravWrap;
  logic [GW-1:0] w_gravInc;
  logic [4:0]    w_velDec;

  assign w_yExt     = {1'b0, r_y};
  assign w_nyUp     = w_yExt - {6'd0, r_vel};
  assign w_nyDown   = w_yExt + {6'd0, r_vel};
  assign w_gravWrap = (r_grav == GW'(G_DIV - 1));
  assign w_gravInc  = w_gravWrap ? '0 : r_grav + 1'b1;
  assign w_velDec   = r_vel - 5'd1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= S_INIT;
    else        r_state <= w_stateNxt;
  end

  always_comb begin
    w_stateNxt = r_state;
    unique case (r_state)
      S_INIT: if (start) w_stateNxt = S_UP;
      S_UP:   if (frame_tick && w_gravWrap && (w_velDec == 5'd0)) w_stateNxt = S_DOWN;
      S_DOWN: begin
        if (frame_tick) begin
          if (plat_hit)                           w_stateNxt = S_UP;
          else if (w_nyDown >= 11'(Y_FLOOR))      w_stateNxt = S_DONE;
        end
      end
      S_DONE: if (ack) w_stateNxt = S_INIT;
      default: w_stateNxt = S_INIT;
    endcase
  end

  // Next values of the registered datapath outputs, plus the state flag decode
  always_comb begin
    w_yNxt         = r_y;
    w_velNxt       = r_vel;
    w_gravNxt      = r_grav;
    w_scoreNxt     = r_score;
    w_scrollAmtNxt = r_scrollAmt;
    w_scrollVldNxt = 1'b0;
    q_I            = (r_state == S_INIT);
    q_Up           = (r_state == S_UP);
    q_Down         = (r_state == S_DOWN);
    q_Done         = (r_state == S_DONE);
    unique case (r_state)
      S_INIT: begin
        if (start) begin
          w_yNxt     = 10'(Y_START);
          w_velNxt   = 5'(V_JUMP);
          w_gravNxt  = '0;
          w_scoreNxt = '0;
        end
      end
      S_UP: begin
        if (frame_tick) begin
          // Rise above the scroll line is handed to the renderer as scroll
          if (w_nyUp < 11'(SCROLL_LINE)) begin
            w_yNxt         = 10'(SCROLL_LINE);
            w_scrollAmtNxt = 5'(11'(SCROLL_LINE) - w_nyUp);
            w_scrollVldNxt = 1'b1;
          end else begin
            w_yNxt = w_nyUp[9:0];
          end
          w_gravNxt = w_gravInc;
          if (w_gravWrap) w_velNxt = w_velDec;
        end
      end
      S_DOWN: begin
        if (frame_tick) begin
          if (plat_hit) begin
            w_velNxt   = 5'(V_JUMP);
            w_gravNxt  = '0;
            w_scoreNxt = (r_score == 16'hFFFF) ? r_score : r_score + 16'd1;
          end else if (w_nyDown >= 11'(Y_FLOOR)) begin
            w_yNxt = 10'(Y_FLOOR);
          end else begin
            w_yNxt    = w_nyDown[9:0];
            w_gravNxt = w_gravInc;
            if (w_gravWrap && (r_vel != 5'(V_MAX))) w_velNxt = r_vel + 5'd1;
          end
        end
      end
      S_DONE: begin
        if (ack) w_yNxt = 10'(Y_START);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_y         <= 10'(Y_START);
      r_vel       <= '0;
      r_grav      <= '0;
      r_score     <= '0;
      r_scrollAmt <= '0;
      r_scrollVld <= 1'b0;
    end else begin
      r_y         <= w_yNxt;
      r_vel       <= w_velNxt;
      r_grav      <= w_gravNxt;
      r_score     <= w_scoreNxt;
      r_scrollAmt <= w_scrollAmtNxt;
      r_scrollVld <= w_scrollVldNxt;
    end
  end

  assign doodle_y   = r_y;
  assign scroll_amt = r_scrollAmt;
  assign scroll_vld = r_scrollVld;
  assign score      = r_score;

endmodule

// File: tb/tb_jump_sequencer.sv
// Scoreboard bench for jump_sequencer: stimulus pushes expected frame results,
// a monitor pops and compares them one cycle after each stimulus cycle.
module tb_jump_sequencer;

  logic        Clk, Reset, frame_tick, start, ack, plat_hit;
  logic [9:0]  doodle_y;
  logic [4:0]  scroll_amt;
  logic        scroll_vld;
  logic [15:0] score;
  logic        q_I, q_Up, q_Down, q_Done;

  jump_sequencer dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start), .ack(ack),
    .plat_hit(plat_hit), .doodle_y(doodle_y), .scroll_amt(scroll_amt),
    .scroll_vld(scroll_vld), .score(score), .q_I(q_I), .q_Up(q_Up),
    .q_Down(q_Down), .q_Done(q_Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int id;
    int st;
    int y;
    int vld;
    int amt;
    int sc;
  } expItem_t;

  expItem_t expQ[$];
  int nCompared = 0;
  int nMismatched = 0;
  int evtNum = 0;
  logic evtFlag = 1'b0;

  // Reference model state: 0 Initial, 1 Up, 2 Down, 3 Done
  int mState, mY, mVel, mGrav, mScore, mVld, mAmt;

  task automatic modelReset();
    mState = 0; mY = 400; mVel = 0; mGrav = 0; mScore = 0; mVld = 0; mAmt = 0;
  endtask

  task automatic modelStep(input int tick, input int st, input int ak, input int hit);
    int ny;
    mVld = 0;
    if (mState == 0) begin
      if (st != 0) begin
        mState = 1; mY = 400; mVel = 12; mGrav = 0; mScore = 0;
      end
    end else if (mState == 1) begin
      if (tick != 0) begin
        ny = mY - mVel;
        if (ny < 160) begin
          mVld = 1; mAmt = 160 - ny; mY = 160;
        end else mY = ny;
        mGrav = mGrav + 1;
        if (mGrav == 4) begin
          mGrav = 0;
          mVel = mVel - 1;
          if (mVel == 0) mState = 2;
        end
      end
    end else if (mState == 2) begin
      if (tick != 0) begin
        if (hit != 0) begin
          mState = 1; mVel = 12; mGrav = 0;
          if (mScore < 65535) mScore = mScore + 1;
        end else if (mY + mVel >= 479) begin
          mState = 3; mY = 479;
        end else begin
          mY = mY + mVel;
          mGrav = mGrav + 1;
          if (mGrav == 4) begin
            mGrav = 0;
            if (mVel < 15) mVel = mVel + 1;
          end
        end
      end
    end else begin
      if (ak != 0) begin
        mState = 0; mY = 400;
      end
    end
  endtask

  task automatic checkVal(input string name, input int actual, input int required);
    nCompared++;
    if (actual != required) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  // One stimulus cycle followed by one idle cycle with all inputs low
  task automatic applyStimulus(input int tick, input int st, input int ak, input int hit);
    expItem_t e;
    @(posedge Clk); #2;
    frame_tick = (tick != 0); start = (st != 0); ack = (ak != 0); plat_hit = (hit != 0);
    evtFlag = 1'b1;
    modelStep(tick, st, ak, hit);
    evtNum++;
    e.id = evtNum; e.st = mState; e.y = mY; e.vld = mVld; e.amt = mAmt; e.sc = mScore;
    expQ.push_back(e);
    @(posedge Clk); #2;
    frame_tick = 1'b0; start = 1'b0; ack = 1'b0; plat_hit = 1'b0;
    evtFlag = 1'b0;
    mVld = 0;
  endtask

  task automatic tickUntilState(input int target, input int budget, input string name);
    int n = 0;
    while (mState != target && n < budget) begin
      applyStimulus(1, 0, 0, 0);
      n++;
    end
    if (mState != target) checkVal({name, "_timeout"}, mState, target);
  endtask

  task automatic tickUntilDownY(input int yTarget, input int budget, input string name);
    int n = 0;
    while (mState == 2 && mY != yTarget && n < budget) begin
      applyStimulus(1, 0, 0, 0);
      n++;
    end
    if (mY != yTarget) checkVal({name, "_timeout"}, mY, yTarget);
  endtask

  // Monitor: every cycle after a stimulus cycle presents one frame result
  always begin : monitor
    logic pend;
    expItem_t e;
    logic [3:0] flagsAct, flagsExp;
    logic bad;
    @(posedge Clk);
    pend = evtFlag;
    #1;
    if (pend) begin
      nCompared++;
      if (expQ.size() == 0) begin
        nMismatched++;
        $display("[TB] FAIL scoreboard_empty: got a result, required a queued expectation");
      end else begin
        e = expQ.pop_front();
        flagsAct = {q_Done, q_Down, q_Up, q_I};
        flagsExp = 4'b0001 << e.st;
        bad = (flagsAct !== flagsExp) || (int'(doodle_y) != e.y) || (int'(score) != e.sc) ||
              (int'(scroll_vld) != e.vld) || ((e.vld != 0) && (int'(scroll_amt) != e.amt));
        if (bad) begin
          nMismatched++;
          $display("[TB] FAIL evt%0d: got flags=%b y=%0d score=%0d vld=%0d amt=%0d, required flags=%b y=%0d score=%0d vld=%0d amt=%0d",
                   e.id, flagsAct, doodle_y, score, scroll_vld, scroll_amt,
                   flagsExp, e.y, e.sc, e.vld, e.amt);
        end
      end
    end
  end

  initial begin
    frame_tick = 1'b0; start = 1'b0; ack = 1'b0; plat_hit = 1'b0;
    Reset = 1'b1;
    modelReset();
    #3 Reset = 1'b0;
    #1;
    checkVal("rst_flags", int'({q_Done, q_Down, q_Up, q_I}), 1);
    checkVal("rst_y", int'(doodle_y), 400);
    checkVal("rst_score", int'(score), 0);
    checkVal("rst_vld", int'(scroll_vld), 0);
    checkVal("rst_amt", int'(scroll_amt), 0);
    #8 Reset = 1'b1;

    repeat (3) applyStimulus(1, 0, 0, 0);
    checkVal("idle_y", int'(doodle_y), 400);

    applyStimulus(0, 1, 0, 0);
    checkVal("start_up", int'(q_Up), 1);
    applyStimulus(1, 0, 0, 0);
    checkVal("tick1_y", int'(doodle_y), 388);
    repeat (3) applyStimulus(1, 0, 0, 0);
    checkVal("tick4_y", int'(doodle_y), 352);
    applyStimulus(1, 0, 0, 0);
    checkVal("vel11_y", int'(doodle_y), 341);

    tickUntilState(2, 100, "reach_down");
    checkVal("down_y", int'(doodle_y), 160);
    tickUntilState(3, 200, "reach_done");
    checkVal("done_flag", int'(q_Done), 1);
    checkVal("done_y", int'(doodle_y), 479);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkVal("ack_y", int'(doodle_y), 400);
    checkVal("ack_flag", int'(q_I), 1);

    applyStimulus(0, 1, 0, 0);
    tickUntilState(2, 100, "arc1_down");
    tickUntilDownY(188, 100, "fall_188");
    applyStimulus(1, 0, 0, 1);
    checkVal("bounce1_score", int'(score), 1);
    checkVal("bounce1_y", int'(doodle_y), 188);
    applyStimulus(1, 0, 0, 0);
    checkVal("rise_176", int'(doodle_y), 176);
    applyStimulus(1, 0, 0, 1);
    checkVal("hit_in_up_y", int'(doodle_y), 164);
    applyStimulus(1, 0, 0, 0);
    checkVal("scroll_y", int'(doodle_y), 160);
    checkVal("scroll_vld", int'(scroll_vld), 1);
    checkVal("scroll_amt", int'(scroll_amt), 8);
    @(posedge Clk); #1;
    checkVal("scroll_pulse_end", int'(scroll_vld), 0);

    tickUntilState(2, 100, "arc2_down");
    tickUntilDownY(184, 100, "fall_184");
    applyStimulus(1, 0, 0, 1);
    checkVal("bounce2_score", int'(score), 2);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkVal("exact_line_y", int'(doodle_y), 160);
    checkVal("exact_line_vld", int'(scroll_vld), 0);

    tickUntilState(2, 100, "arc3_down");
    applyStimulus(1, 0, 0, 1);
    checkVal("bounce3_score", int'(score), 3);
    checkVal("bounce3_y", int'(doodle_y), 160);
    applyStimulus(1, 0, 0, 0);
    checkVal("scroll12_amt", int'(scroll_amt), 12);

    applyStimulus(1, 0, 0, 0);
    @(posedge Clk); #4;
    Reset = 1'b0;
    #1;
    checkVal("midup_rst_flag", int'(q_I), 1);
    checkVal("midup_rst_y", int'(doodle_y), 400);
    checkVal("midup_rst_score", int'(score), 0);
    modelReset();
    #3 Reset = 1'b1;
    repeat (2) applyStimulus(1, 0, 0, 0);
    checkVal("post_rst_y", int'(doodle_y), 400);

    repeat (3) @(posedge Clk);
    #3;
    checkVal("queue_drained", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/jump_sequencer.md
Name: jump_sequencer

Overview:
- Frame-rate motion and game-phase controller for the doodle game.
- Sequences the doodle's vertical position, velocity, screen scroll and score once per video frame. Phases: Initial, Up, Down, Done.
- Takes an end-of-frame pulse from the display timing path and a platform-contact flag from the pixel/bitchange logic.
- Drives doodle Y, scroll amount and score to the renderer, and drives the score to the seven-segment counter.

Parameters:
- Y_START, 400, doodle Y (feet, screen lines) loaded on game start
- V_JUMP, 12, initial upward speed in lines/frame after start or platform bounce
- V_MAX, 15, downward speed saturation, lines/frame
- G_DIV, 4, frames per 1-unit gravity step (>=1)
- SCROLL_LINE, 160, highest Y the doodle may occupy; excess rise becomes scroll
- Y_FLOOR, 479, Y at or beyond which the doodle is lost

Ports:
- Clk  in  1  system clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame, asserted in vertical blanking
- start  in  1  level; begin game from Initial
- ack  in  1  level; leave Done back to Initial
- plat_hit  in  1  doodle feet overlap a platform; meaningful only when frame_tick=1
- doodle_y  out  10  current doodle Y
- scroll_amt  out  5  lines to scroll platforms this frame; valid while scroll_vld=1
- scroll_vld  out  1  one-cycle pulse carrying scroll_amt
- score  out  16  bounces since start, unsigned binary, saturates at 16'hFFFF
- q_I, q_Up, q_Down, q_Done  out  1 each  one-hot state flags

Behaviour:
- Reset low, at any time and asynchronously: state=Initial, doodle_y=Y_START, vel=0, grav_cnt=0, score=0, scroll_amt=0, scroll_vld=0, q_I=1, all other flags 0.
- Internal registers: vel (5-bit magnitude), grav_cnt (0..G_DIV-1). All outputs are registered. Any update is visible in the cycle after the edge that sampled the input.
- Initial:
  - start=1 -> Up; vel=V_JUMP; doodle_y=Y_START; score=0; grav_cnt=0.
  - start does not need to coincide with frame_tick.
- Up (acts only on cycles where frame_tick=1):
  - ny = doodle_y - vel.
  - If ny < SCROLL_LINE: doodle_y=SCROLL_LINE; scroll_amt=SCROLL_LINE-ny; scroll_vld=1 for that one cycle.
  - Otherwise doodle_y=ny.
  - grav_cnt increments. On wrap from G_DIV-1 to 0, vel decrements.
  - When the decremented vel equals 0 -> Down, with vel=0.
  - plat_hit is ignored in Up.
- Down (acts only on cycles where frame_tick=1, in this priority order):
  1. plat_hit=1 -> Up; vel=V_JUMP; grav_cnt=0; score+1 (saturating); doodle_y unchanged.
  2. Else if doodle_y+vel >= Y_FLOOR -> Done; doodle_y=Y_FLOOR.
  3. Else doodle_y += vel. grav_cnt advances; on wrap, vel increments, saturating at V_MAX.
- Done:
  - doodle_y, score and vel hold; frame_tick is ignored.
  - ack=1 -> Initial; doodle_y=Y_START; score holds until the next start.
- Timing and arithmetic rules:
  - frame_tick outside Up/Down has no effect.
  - start and ack are ignored outside Initial and Done respectively. Holding start through Done->Initial restarts on the next cycle.
  - scroll_vld is never asserted outside Up and is low every cycle without frame_tick.
  - All Y arithmetic is done in 11 bits to avoid wrap. doodle_y never goes below SCROLL_LINE and never exceeds Y_FLOOR.
  - Exactly one q_* flag is high at all times.
  - Reset asserted mid-frame or mid-jump aborts immediately. No tick is remembered.

Test Plan:
- Reset low, then high; hold start=0 for 3 frame_ticks -> q_I=1, doodle_y=400, score=0, scroll_vld never 1.
- Pulse start, then 1 frame_tick -> q_Up=1, doodle_y=388; after 4 ticks vel=11.
- Start with plat_hit=0 throughout, run frames until vel reaches 0 -> q_Down=1; keep ticking -> q_Done with doodle_y=479; assert ack -> q_I=1, doodle_y=400.
- In Down, assert plat_hit with frame_tick -> next cycle q_Up=1, score=1; repeat 3 bounces -> score=3, each doodle_y unchanged on the bounce cycle.
- Force doodle_y=165 in Up with vel=12 (via a sequence of bounces), then tick -> doodle_y=160, scroll_vld=1 for one cycle, scroll_amt=7.
- Assert Reset low mid-Up between ticks -> same cycle q_I=1, doodle_y=400, score=0; release and tick without start -> no change.
